// File: rtl/alu_issue_unit.sv
// alu_issue_unit: request front end for the combinational escalar_ALU.
// Registers one tagged request onto the ALU ports, waits the op settle
// time, captures result and flags, and queues them in a small response
// FIFO. Also tracks last/sticky status and a retire counter.
module alu_issue_unit #(
    parameter int W          = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int ALU_LAT    = 1,
    parameter int MUL_LAT    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic             req_cin,
    input  logic [TAG_W-1:0] req_tag,
    output logic             alu_cin,
    output logic [2:0]       alu_op,
    output logic [W-1:0]     alu_opa,
    output logic [W-1:0]     alu_opb,
    input  logic             alu_cout,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    input  logic             alu_eq,
    input  logic             alu_bgt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic [6:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,
    output logic [6:0]       last_flags,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [15:0]      retire_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int LAT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0] OP_MUL = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RETIRE = 2'd2
    } state_t;

    // Opcodes 011 and 111 have no ALU function.
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            3'b011:  legal = 1'b0;
            3'b111:  legal = 1'b0;
            default: legal = 1'b1;
        endcase
        return legal;
    endfunction

    state_t             state_r, state_next_s;
    logic [LAT_W-1:0]   lat_r, lat_next_s;
    logic               accept_s, sample_s, push_s, pop_s, retire_legal_s;
    logic [W-1:0]       res_r;
    logic [6:0]         flags_r;
    logic [TAG_W-1:0]   tag_r;
    logic               illegal_r;
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [W-1:0]       mem_result_r [FIFO_DEPTH];
    logic [6:0]         mem_flags_r  [FIFO_DEPTH];
    logic [TAG_W-1:0]   mem_tag_r    [FIFO_DEPTH];
    logic               mem_ill_r    [FIFO_DEPTH];

    assign req_ready      = (state_r == ST_IDLE) && (count_r < DEPTH_C);
    assign accept_s       = req_valid && req_ready;
    assign push_s         = (state_r == ST_RETIRE);
    assign retire_legal_s = push_s && !illegal_r;
    assign rsp_valid      = (count_r != {CNT_W{1'b0}});
    assign pop_s          = rsp_valid && rsp_ready;
    assign rsp_result     = mem_result_r[rd_ptr_r];
    assign rsp_flags      = mem_flags_r[rd_ptr_r];
    assign rsp_tag        = mem_tag_r[rd_ptr_r];
    assign rsp_illegal    = mem_ill_r[rd_ptr_r];

    // Next-state and settle-counter logic for the issue FSM.
    always_comb begin
        state_next_s = state_r;
        lat_next_s   = lat_r;
        sample_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op_is_legal(req_op)) begin
                        state_next_s = ST_EXEC;
                        lat_next_s   = (req_op == OP_MUL) ? LAT_W'(MUL_LAT - 1) : LAT_W'(ALU_LAT - 1);
                    end else begin
                        state_next_s = ST_RETIRE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (lat_r == {LAT_W{1'b0}}) begin
                    state_next_s = ST_RETIRE;
                    sample_s     = 1'b1;
                end else begin
                    lat_next_s = lat_r - LAT_W'(1);
                end
            end
            ST_RETIRE: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            lat_r   <= {LAT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            lat_r   <= lat_next_s;
        end
    end

    // ALU port registers, loaded on accept and held through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op  <= 3'd0;
            alu_opa <= {W{1'b0}};
            alu_opb <= {W{1'b0}};
            alu_cin <= 1'b0;
        end else if (accept_s) begin
            alu_op  <= req_op;
            alu_opa <= req_a;
            alu_opb <= req_b;
            alu_cin <= req_cin;
        end
    end

    // Response capture: zeros for illegal ops, ALU outputs once settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r     <= {W{1'b0}};
            flags_r   <= 7'd0;
            tag_r     <= {TAG_W{1'b0}};
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            tag_r     <= req_tag;
            illegal_r <= !op_is_legal(req_op);
            res_r     <= {W{1'b0}};
            flags_r   <= 7'd0;
        end else if (sample_s) begin
            res_r   <= alu_result;
            flags_r <= {alu_cout, alu_bgt, alu_eq, alu_negative, alu_overflow, alu_carry, alu_zero};
        end
    end

    // Response FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_result_r[i] <= {W{1'b0}};
                mem_flags_r[i]  <= 7'd0;
                mem_tag_r[i]    <= {TAG_W{1'b0}};
                mem_ill_r[i]    <= 1'b0;
            end
        end else begin
            if (push_s) begin
                mem_result_r[wr_ptr_r] <= res_r;
                mem_flags_r[wr_ptr_r]  <= flags_r;
                mem_tag_r[wr_ptr_r]    <= tag_r;
                mem_ill_r[wr_ptr_r]    <= illegal_r;
                wr_ptr_r               <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer status: last legal flags, sticky overflow (set wins), retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_flags <= 7'd0;
            sticky_ovf <= 1'b0;
            retire_cnt <= 16'd0;
        end else begin
            if (retire_legal_s) begin
                last_flags <= flags_r;
            end
            sticky_ovf <= (sticky_ovf && !clr_sticky) || (retire_legal_s && flags_r[2]);
            if (push_s) begin
                retire_cnt <= retire_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit with a behavioural ALU.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0, req_b = 32'd0;
    logic        req_cin = 1'b0;
    logic [3:0]  req_tag = 4'd0;
    logic        alu_cin;
    logic [2:0]  alu_op;
    logic [31:0] alu_opa, alu_opb;
    logic        alu_cout, alu_zero, alu_carry, alu_overflow, alu_negative, alu_eq, alu_bgt;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [6:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        rsp_illegal;
    logic [6:0]  last_flags;
    logic        sticky_ovf;
    logic        clr_sticky = 1'b0;
    logic [15:0] retire_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_tag(req_tag),
        .alu_cin(alu_cin), .alu_op(alu_op), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_cout(alu_cout), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_negative(alu_negative),
        .alu_eq(alu_eq), .alu_bgt(alu_bgt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
        .last_flags(last_flags), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
        .retire_cnt(retire_cnt)
    );

    // Behavioural escalar_ALU driven by the DUT's registered ALU ports.
    logic [32:0] sum;
    always_comb begin
        sum          = 33'd0;
        alu_result   = 32'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: begin
                sum          = {1'b0, alu_opa} + {1'b0, alu_opb} + {32'd0, alu_cin};
                alu_result   = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_opa[31] == alu_opb[31]) && (sum[31] != alu_opa[31]);
            end
            3'b001: begin
                sum          = {1'b0, alu_opa} + {1'b0, ~alu_opb} + 33'd1;
                alu_result   = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_opa[31] != alu_opb[31]) && (sum[31] != alu_opa[31]);
            end
            3'b010:  alu_result = alu_opa * alu_opb;
            3'b100:  alu_result = alu_opa << alu_opb[4:0];
            3'b101:  alu_result = alu_opa & alu_opb;
            3'b110:  alu_result = alu_opa >> alu_opb[4:0];
            default: alu_result = 32'd0;
        endcase
        alu_zero     = (alu_result == 32'd0);
        alu_negative = alu_result[31];
        alu_eq       = (alu_opa == alu_opb);
        alu_bgt      = ($signed(alu_opa) > $signed(alu_opb));
        alu_cout     = alu_carry;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [3:0] tag);
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("accept_timeout", 64'(k), 64'd0);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin; req_tag = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_retire(input string tag, input logic [15:0] exp_cnt, input int exp_lat);
        int  k = 0;
        bit  done = 1'b0;
        while (!done && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (retire_cnt == exp_cnt) done = 1'b1;
        end
        chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    endtask

    task automatic pop(input string tag, input logic [31:0] res, input logic [6:0] flg,
                       input logic [3:0] t, input logic ill);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_result"}, 64'(rsp_result), 64'(res));
        chk({tag, "_flags"}, 64'(rsp_flags), 64'(flg));
        chk({tag, "_tag"}, 64'(rsp_tag), 64'(t));
        chk({tag, "_illegal"}, 64'(rsp_illegal), 64'(ill));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_opa", 64'(alu_opa), 64'd0);
        chk("rst_alu_cin", 64'(alu_cin), 64'd0);
        chk("rst_last_flags", 64'(last_flags), 64'd0);
        chk("rst_sticky", 64'(sticky_ovf), 64'd0);
        chk("rst_retire_cnt", 64'(retire_cnt), 64'd0);
        #10 rst_n = 1'b1;

        // add 3+2
        issue(3'b000, 32'd3, 32'd2, 1'b0, 4'd1);
        wait_retire("add", 16'd1, 2);
        chk("add_last_flags", 64'(last_flags), 64'h20);
        pop("add", 32'd5, 7'b0100000, 4'd1, 1'b0);

        // sub 5-10
        issue(3'b001, 32'd5, 32'd10, 1'b0, 4'd7);
        wait_retire("sub", 16'd2, 2);
        chk("sub_last_flags", 64'(last_flags), 64'h08);
        chk("sub_retire_cnt", 64'(retire_cnt), 64'd2);
        pop("sub", 32'hFFFF_FFFB, 7'b0001000, 4'd7, 1'b0);

        // mul 1000*30: operands held through EXEC, response MUL_LAT+1 after accept
        issue(3'b010, 32'd1000, 32'd30, 1'b0, 4'd8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mul_hold_op", 64'(alu_op), 64'd2);
            chk("mul_hold_opa", 64'(alu_opa), 64'd1000);
            chk("mul_hold_opb", 64'(alu_opb), 64'd30);
            chk("mul_not_yet", 64'(rsp_valid), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("mul_valid_at_3", 64'(rsp_valid), 64'd1);
        pop("mul", 32'd30000, 7'b0100000, 4'd8, 1'b0);

        // backpressure: two responses fill the FIFO
        issue(3'b100, 32'd10, 32'd2, 1'b0, 4'd2);
        wait_retire("sll", 16'd4, 2);
        issue(3'b101, 32'd10, 32'd1, 1'b0, 4'd3);
        wait_retire("and", 16'd5, 2);
        chk("full_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("full_req_ready_hold", 64'(req_ready), 64'd0);
        chk("full_head_stable", 64'(rsp_result), 64'd40);
        pop("bp_sll", 32'd40, 7'b0100000, 4'd2, 1'b0);
        pop("bp_and", 32'd0, 7'b0100001, 4'd3, 1'b0);
        @(negedge clk);
        chk("drained_valid", 64'(rsp_valid), 64'd0);
        issue(3'b110, 32'd10, 32'd1, 1'b0, 4'd4);
        wait_retire("srl", 16'd6, 2);
        pop("srl", 32'd5, 7'b0100000, 4'd4, 1'b0);

        // illegal opcode
        issue(3'b011, 32'd1, 32'd2, 1'b0, 4'd5);
        wait_retire("ill", 16'd7, 1);
        chk("ill_last_flags", 64'(last_flags), 64'h20);
        pop("ill", 32'd0, 7'd0, 4'd5, 1'b1);

        // overflow sets sticky
        issue(3'b000, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd6);
        wait_retire("ovf", 16'd8, 2);
        chk("ovf_sticky", 64'(sticky_ovf), 64'd1);
        chk("ovf_last_flags", 64'(last_flags), 64'h2C);
        pop("ovf", 32'h8000_0000, 7'b0101100, 4'd6, 1'b0);

        // clear sticky
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        @(negedge clk);
        chk("clr_sticky", 64'(sticky_ovf), 64'd0);

        // clear during an overflow retire: set wins
        clr_sticky = 1'b1;
        issue(3'b000, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd9);
        wait_retire("setwin", 16'd9, 2);
        chk("setwin_sticky", 64'(sticky_ovf), 64'd1);
        clr_sticky = 1'b0;
        pop("setwin", 32'h8000_0000, 7'b0101100, 4'd9, 1'b0);

        // reset mid-multiply
        issue(3'b010, 32'd7, 32'd6, 1'b0, 4'd10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mrst_alu_op", 64'(alu_op), 64'd0);
        chk("mrst_alu_opa", 64'(alu_opa), 64'd0);
        chk("mrst_retire_cnt", 64'(retire_cnt), 64'd0);
        chk("mrst_last_flags", 64'(last_flags), 64'd0);
        chk("mrst_sticky", 64'(sticky_ovf), 64'd0);
        chk("mrst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mrst_no_rsp", 64'(rsp_valid), 64'd0);
        chk("mrst_no_retire", 64'(retire_cnt), 64'd0);
        issue(3'b000, 32'd3, 32'd4, 1'b0, 4'd11);
        wait_retire("post_rst", 16'd1, 2);
        pop("post_rst", 32'd7, 7'b0000000, 4'd11, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
